// File: rtl/srt_tx_arbiter.sv
// srt_tx_arbiter: round-robin arbiter that sequences N requesters onto one serial transmitter
module srt_tx_arbiter #(
    parameter int N = 4,
    parameter int TMO = 4096,
    parameter int ACKW = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           abort,
    output logic           send,
    output logic [7:0]     d,
    input  logic           rts,
    output logic           ack,
    output logic           busy
);
    localparam int PW = $clog2(N);
    localparam int WW = $clog2(TMO + 2);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, ACKS, REL, ABRT} state_t;
    state_t        state;
    logic [PW-1:0] ptr, win, idx;
    logic [WW-1:0] wd;
    logic [1:0]    ac;
    logic [7:0]    lane [N];
    // lowest offset from ptr wins, so scan offsets from the top down
    always_comb begin
        win = ptr;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) win = idx;
        end
        for (int i = 0; i < N; i++) lane[i] = din[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        send  <= 1'b0;
        done  <= '0;
        abort <= 1'b0;
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            d     <= 8'h00;
            ptr   <= '0;
            wd    <= '0;
            ac    <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                    gnt   <= N'(1) << win;
                    d     <= lane[win];
                    ptr   <= (int'(win) == N - 1) ? '0 : win + 1'b1;
                end
                LOAD: begin
                    state <= SEND;
                    send  <= 1'b1;
                    wd    <= '0;
                end
                SEND: begin
                    state <= WAIT;
                    wd    <= wd + 1'b1;
                end
                // wd counts cycles since the send pulse; rts beats a same-cycle timeout
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (rts) begin
                        state <= ACKS;
                        ack   <= 1'b1;
                        ac    <= '0;
                    end else if (TMO != 0 && int'(wd) >= TMO - 1) begin
                        state <= ABRT;
                        done  <= gnt;
                        abort <= 1'b1;
                        gnt   <= '0;
                    end
                end
                ACKS: if (ac == 2'(ACKW - 1)) begin
                    state <= REL;
                    ack   <= 1'b0;
                end else ac <= ac + 1'b1;
                REL: if (!rts) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= gnt;
                    gnt   <= '0;
                end
                ABRT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_srt_tx_arbiter.sv
// tb_srt_tx_arbiter: scoreboard bench with a round-robin reference model and a transmitter model
module tb_srt_tx_arbiter;
    localparam int N = 4;
    localparam int TMO = 16;
    localparam int ACKW = 1;

    typedef struct {
        int         lane;
        logic [7:0] b;
        int         dly;
        int         hold;
        int         rc;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [8*N-1:0] din;
    logic [N-1:0] gnt, done;
    logic         abort, send, ack, busy, rts;
    logic [7:0]   d;

    srt_tx_arbiter #(.N(N), .TMO(TMO), .ACKW(ACKW)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .done(done),
        .abort(abort), .send(send), .d(d), .rts(rts), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int   checks = 0;
    int   failures = 0;
    ent_t sb[$];
    ent_t txq[$];
    int   plan[$];
    logic [7:0] lane_b [N];
    int   ptr_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_abort(input ent_t e);
        return e.dly < 0 || e.dly >= TMO;
    endfunction

    // send-to-done distance: rts seen at send+dly, ack starts one later, release waits for both ack width and rts drop
    function automatic int exp_off(input ent_t e);
        if (is_abort(e)) return TMO;
        return e.dly + 2 + ((ACKW > e.hold) ? ACKW : e.hold);
    endfunction

    function automatic int pick(input logic [N-1:0] m);
        int w;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && m[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        ptr_m = (w + 1) % N;
        return w;
    endfunction

    // monitor: pops an expectation at each send, closes it at the matching done
    ent_t cur;
    bit   inflight = 0;
    int   send_cyc = 0;
    int   ack_n = 0;
    int   since_done = 99;
    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_outputs", {gnt, done, abort, send, d, ack, busy}, 0);
            sb.delete();
            inflight = 0;
            since_done = 99;
        end else begin
            if (send || ack || |done) chk("one_of_send_ack_done", $countones({send, ack, |done}), 1);
            if (abort && done == '0) chk("abort_without_done", {31'd0, abort}, 0);
            if (ack && !inflight) chk("ack_outside_frame", {31'd0, ack}, 0);
            if (|done) begin
                if (!inflight) chk("done_unexpected", {28'd0, done}, 0);
                else begin
                    chk("done_lane", {28'd0, done}, 32'd1 << cur.lane);
                    chk("abort_flag", {31'd0, abort}, {31'd0, is_abort(cur)});
                    chk("gnt_cleared", {28'd0, gnt}, 0);
                    chk("done_cycle", cyc - send_cyc, exp_off(cur));
                    chk("ack_cycles", ack_n, is_abort(cur) ? 0 : ACKW);
                end
                inflight = 0;
                since_done = 0;
            end else if (inflight) begin
                if (ack) ack_n++;
                chk("hold_gnt_d", {20'd0, gnt, d}, (32'd1 << (cur.lane + 8)) | {24'd0, cur.b});
                chk("busy_in_frame", {31'd0, busy}, 1);
            end
            if (send) begin
                if (sb.size() == 0) chk("send_unexpected", {31'd0, send}, 0);
                else begin
                    cur = sb.pop_front();
                    inflight = 1;
                    send_cyc = cyc;
                    ack_n = 0;
                    chk("send_d", {24'd0, d}, {24'd0, cur.b});
                    chk("send_gnt", {28'd0, gnt}, 32'd1 << cur.lane);
                    if (cur.rc >= 0) chk("req_to_send_latency", cyc - cur.rc, 2);
                end
            end
            if (!inflight && done == '0) begin
                since_done++;
                if (since_done == 1 && sb.size() == 0) chk("busy_after_done", {31'd0, busy}, 0);
            end
        end
    end

    // transmitter model: raises rts dly cycles after send, drops it hold cycles after ack
    ent_t te;
    initial begin
        rts = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_q) txq.delete();
            else if (send && txq.size() != 0) begin
                te = txq.pop_front();
                if (te.dly >= 0) begin
                    repeat (te.dly) @(negedge clk);
                    rts = 1'b1;
                    for (int n = 0; n < 64 && !ack; n++) @(negedge clk);
                    repeat (te.hold) @(negedge clk);
                    rts = 1'b0;
                end
            end
        end
    end

    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3);
        lane_b[0] = b0; lane_b[1] = b1; lane_b[2] = b2; lane_b[3] = b3;
        for (int i = 0; i < N; i++) din[8*i +: 8] = lane_b[i];
    endtask

    task automatic play(input int c0, c1, c2, c3, input bit wait_end);
        int cnt[N];
        int rem[N];
        int w;
        int n;
        ent_t e;
        logic [N-1:0] m;
        bit first;
        cnt = '{c0, c1, c2, c3};
        rem = cnt;
        first = 1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            m = '0;
            for (int i = 0; i < N; i++) if (rem[i] > 0) m[i] = 1'b1;
            if (m == '0) break;
            w = pick(m);
            rem[w]--;
            e.lane = w;
            e.b = lane_b[w];
            if (plan.size() >= 2) begin
                e.dly = plan.pop_front();
                e.hold = plan.pop_front();
            end else begin
                e.dly = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(15, 1));
                e.hold = int'($urandom_range(3));
            end
            e.rc = first ? cyc : -1;
            first = 0;
            sb.push_back(e);
            txq.push_back(e);
        end
        for (int i = 0; i < N; i++) req[i] = cnt[i] > 0;
        if (!wait_end) return;
        n = 0;
        while ((req != '0 || sb.size() != 0 || inflight) && n < 3000) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++)
                if (done[i] && cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) req[i] = 1'b0;
                end
        end
        if (n >= 3000) begin
            $display("FAIL frame_timeout: %0d expectations still pending at cycle %0d", sb.size(), cyc);
            $fatal(1, "frames did not complete");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c[N];
        rst = 1'b1;
        req = '0;
        din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        set_bytes(8'h10, 8'h21, 8'h32, 8'h43);
        repeat (5) begin plan.push_back(3); plan.push_back(1); end
        play(2, 1, 1, 1, 1);
        plan = '{4, 0};
        play(0, 0, 0, 1, 1);
        plan = '{2, 1, 6, 2};
        play(1, 0, 1, 0, 1);
        set_bytes(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        plan = '{12, 1};
        play(1, 0, 0, 0, 1);
        plan = '{-1, 0, 4, 1};
        play(0, 1, 0, 0, 1);
        play(0, 1, 0, 0, 1);
        plan = '{15, 1, 4, 5};
        play(0, 0, 1, 0, 1);
        play(0, 0, 1, 0, 1);
        repeat (25) begin
            set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            for (int i = 0; i < N; i++) c[i] = int'($urandom_range(2));
            if (c[0] + c[1] + c[2] + c[3] == 0) c[$urandom_range(3)] = 1;
            play(c[0], c[1], c[2], c[3], 1);
        end
        plan = '{-1, 0};
        play(0, 0, 1, 0, 0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
        plan = '{3, 1, 3, 1};
        play(0, 1, 0, 1, 1);
        plan = '{5, 2};
        play(0, 1, 0, 0, 1);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
